// File: rtl/adder_error_monitor.sv
// Clocked checker comparing a DUV adder against a reference adder.
// Accumulates mismatch counts and error-distance statistics over a
// fixed-length run of accepted vectors, then holds them in DONE.
module adder_error_monitor #(
  parameter int N       = 8,
  parameter int VECTORS = 30000,
  parameter int TYPE    = 1,
  parameter int CNT_W   = 32,
  parameter int SUM_W   = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [N-1:0]     s_ref,
  input  logic             cout_ref,
  input  logic             prop_ref,
  input  logic             gen_ref,
  input  logic [N-1:0]     s_duv,
  input  logic             cout_duv,
  input  logic             prop_duv,
  input  logic             gen_duv,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] pg_err_count,
  output logic [N:0]       max_ed,
  output logic [SUM_W-1:0] sum_ed,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic           accept, last, clear;
  logic [N:0]     r_full, d_full, ed;
  logic           sd_mis, pg_mis;
  logic [SUM_W:0] sum_ext;

  // Control qualifiers: vector acceptance, final vector, run (re)start
  always_comb begin
    accept = (state == RUN) && in_valid;
    last   = accept && (vec_count == CNT_W'(VECTORS - 1));
    clear  = (state != RUN) && start;
  end

  // Per-vector comparison and error distance (ED never wraps: N+1 bits)
  always_comb begin
    r_full  = {cout_ref, s_ref};
    d_full  = {cout_duv, s_duv};
    ed      = (r_full >= d_full) ? (r_full - d_full) : (d_full - r_full);
    sd_mis  = (r_full != d_full);
    pg_mis  = (TYPE == 1) && ((prop_ref != prop_duv) || (gen_ref != gen_duv));
    sum_ext = {1'b0, sum_ed} + (SUM_W + 1)'(ed);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Statistics accumulators: cleared on run start, updated per accepted vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch        <= 1'b0;
      vec_count       <= '0;
      err_count       <= '0;
      pg_err_count    <= '0;
      max_ed          <= '0;
      sum_ed          <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
    end else if (clear) begin
      mismatch        <= 1'b0;
      vec_count       <= '0;
      err_count       <= '0;
      pg_err_count    <= '0;
      max_ed          <= '0;
      sum_ed          <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
    end else if (accept) begin
      mismatch  <= sd_mis || pg_mis;
      vec_count <= (vec_count == '1) ? vec_count : vec_count + 1'b1;
      if (sd_mis && (err_count != '1))
        err_count <= err_count + 1'b1;
      if (pg_mis && (pg_err_count != '1))
        pg_err_count <= pg_err_count + 1'b1;
      if (ed > max_ed)
        max_ed <= ed;
      sum_ed <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      if (sd_mis && !first_err_valid) begin
        first_err_idx   <= vec_count;
        first_err_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adder_error_monitor.sv
// Scoreboard bench for adder_error_monitor (N=8, VECTORS=4, TYPE=1).
module tb_adder_error_monitor;

  localparam int N = 8;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  s_ref = '0, s_duv = '0;
  logic        cout_ref = 1'b0, prop_ref = 1'b0, gen_ref = 1'b0;
  logic        cout_duv = 1'b0, prop_duv = 1'b0, gen_duv = 1'b0;
  logic        busy, done, mismatch, first_err_valid;
  logic [31:0] vec_count, err_count, pg_err_count, first_err_idx;
  logic [8:0]  max_ed;
  logic [47:0] sum_ed;

  adder_error_monitor #(.N(N), .VECTORS(V), .TYPE(1), .CNT_W(32), .SUM_W(48)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .s_ref(s_ref), .cout_ref(cout_ref), .prop_ref(prop_ref), .gen_ref(gen_ref),
    .s_duv(s_duv), .cout_duv(cout_duv), .prop_duv(prop_duv), .gen_duv(gen_duv),
    .busy(busy), .done(done), .mismatch(mismatch), .vec_count(vec_count),
    .err_count(err_count), .pg_err_count(pg_err_count), .max_ed(max_ed),
    .sum_ed(sum_ed), .first_err_idx(first_err_idx), .first_err_valid(first_err_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        mm;
    logic [31:0] vc, ec, pc;
    logic [8:0]  mx;
    logic [47:0] se;
    logic [31:0] fi;
    logic        fv;
    logic        dn;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;

  exp_t  q[$];
  exp_t  m;
  exp_t  e;
  mode_t mode = M_IDLE;
  logic [31:0] prev_vc = '0;

  // Monitor: every advance of vec_count presents one vector's results
  always @(negedge clk) begin
    if (!rst_n) prev_vc = '0;
    else if (vec_count !== prev_vc) begin
      if (vec_count != 0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: vec_count %0h with empty scoreboard", vec_count);
        end else begin
          e = q.pop_front();
          chk("sb_mismatch", mismatch, e.mm);
          chk("sb_vec_count", vec_count, e.vc);
          chk("sb_err_count", err_count, e.ec);
          chk("sb_pg_err_count", pg_err_count, e.pc);
          chk("sb_max_ed", max_ed, e.mx);
          chk("sb_sum_ed", sum_ed, e.se);
          chk("sb_first_err_idx", first_err_idx, e.fi);
          chk("sb_first_err_valid", first_err_valid, e.fv);
          chk("sb_done", done, e.dn);
        end
      end
      prev_vc = vec_count;
    end
  end

  // One clock of stimulus; the expected result is pushed when a vector is issued in RUN
  task automatic vec(input logic v, input logic st, input logic [8:0] r, input logic [8:0] d,
                     input logic pd, input logic gd);
    int ed;
    in_valid = v;
    start    = st;
    {cout_ref, s_ref} = r;
    {cout_duv, s_duv} = d;
    prop_ref = 1'b0;
    gen_ref  = 1'b0;
    prop_duv = pd;
    gen_duv  = gd;
    if (mode == M_RUN && v) begin
      ed = (r > d) ? (int'(r) - int'(d)) : (int'(d) - int'(r));
      m.mm = (r != d) || pd || gd;
      if (r != d && !m.fv) begin
        m.fi = m.vc;
        m.fv = 1'b1;
      end
      m.vc = m.vc + 1;
      if (r != d) m.ec = m.ec + 1;
      if (pd || gd) m.pc = m.pc + 1;
      m.se = m.se + 48'(ed);
      if (ed > int'(m.mx)) m.mx = 9'(ed);
      if (m.vc == V) begin
        mode = M_DONE;
        m.dn = 1'b1;
      end
      q.push_back(m);
    end else if (mode != M_RUN && st) begin
      m    = '0;
      mode = M_RUN;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mismatch"}, mismatch, 0);
    chk({tag, "_vec_count"}, vec_count, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_pg_err_count"}, pg_err_count, 0);
    chk({tag, "_max_ed"}, max_ed, 0);
    chk({tag, "_sum_ed"}, sum_ed, 0);
    chk({tag, "_first_err_idx"}, first_err_idx, 0);
    chk({tag, "_first_err_valid"}, first_err_valid, 0);
  endtask

  // Asynchronous reset pulse; outputs must clear before any clock edge
  task automatic do_reset(input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_queue_drained"}, q.size(), 0);
    rst_n = 1'b0;
    #2;
    chk_zero(tag);
    q.delete();
    m    = '0;
    mode = M_IDLE;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic final_chk(input string tag, input logic [31:0] vc, ec, pc, input logic [8:0] mx,
                           input logic [47:0] se, input logic [31:0] fi, input logic fv);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_vec_count"}, vec_count, vc);
    chk({tag, "_err_count"}, err_count, ec);
    chk({tag, "_pg_err_count"}, pg_err_count, pc);
    chk({tag, "_max_ed"}, max_ed, mx);
    chk({tag, "_sum_ed"}, sum_ed, se);
    chk({tag, "_first_err_idx"}, first_err_idx, fi);
    chk({tag, "_first_err_valid"}, first_err_valid, fv);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset while idle, then start with no vectors
    do_reset("idle_rst");
    vec(0, 1, 9'h000, 9'h000, 0, 0);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_vec_count", vec_count, 0);

    // Four exact vectors
    vec(1, 0, 9'h0FF, 9'h0FF, 0, 0);
    vec(1, 0, 9'h100, 9'h100, 0, 0);
    vec(1, 0, 9'h000, 9'h000, 0, 0);
    vec(1, 0, 9'h1FE, 9'h1FE, 0, 0);
    final_chk("exact", 4, 0, 0, 0, 0, 0, 0);

    // Two sum/cout errors (ED 1 and 8), restarted from DONE
    vec(0, 1, 9'h000, 9'h000, 0, 0);
    vec(1, 0, 9'h100, 9'h0FF, 0, 0);
    vec(1, 0, 9'h010, 9'h018, 0, 0);
    vec(1, 0, 9'h055, 9'h055, 0, 0);
    vec(1, 0, 9'h1AA, 9'h1AA, 0, 0);
    final_chk("errs", 4, 2, 0, 8, 9, 0, 1);

    // Only prop differs on vector 2
    vec(0, 1, 9'h000, 9'h000, 0, 0);
    vec(1, 0, 9'h033, 9'h033, 0, 0);
    vec(1, 0, 9'h044, 9'h044, 0, 0);
    vec(1, 0, 9'h077, 9'h077, 1, 0);
    vec(1, 0, 9'h088, 9'h088, 0, 0);
    final_chk("pg", 4, 0, 1, 0, 0, 0, 0);
    chk("pg_last_mismatch", mismatch, 0);

    // in_valid gaps 1,0,0,1,1,0,1 with start pulses during RUN
    vec(0, 1, 9'h000, 9'h000, 0, 0);
    vec(1, 0, 9'h010, 9'h011, 0, 0);
    vec(0, 1, 9'h000, 9'h000, 0, 0);
    chk("gap_mm_hold1", mismatch, 1);
    chk("gap_busy", busy, 1);
    vec(0, 0, 9'h000, 9'h000, 0, 0);
    chk("gap_mm_hold2", mismatch, 1);
    chk("gap_vec_count", vec_count, 1);
    vec(1, 1, 9'h022, 9'h022, 0, 0);
    vec(1, 0, 9'h033, 9'h033, 0, 0);
    vec(0, 1, 9'h000, 9'h000, 0, 0);
    chk("gap_busy2", busy, 1);
    vec(1, 0, 9'h044, 9'h044, 0, 0);
    final_chk("gap", 4, 1, 0, 1, 1, 0, 1);
    vec(1, 0, 9'h055, 9'h056, 0, 0);
    vec(1, 0, 9'h055, 9'h056, 1, 1);
    final_chk("done_hold", 4, 1, 0, 1, 1, 0, 1);

    // Reset mid-run after two vectors discards partial statistics
    vec(0, 1, 9'h000, 9'h000, 0, 0);
    vec(1, 0, 9'h0AA, 9'h0AB, 0, 0);
    vec(1, 0, 9'h0CC, 9'h0C0, 1, 0);
    do_reset("midrun_rst");

    // start with in_valid in IDLE: vector not counted
    vec(1, 1, 9'h1FF, 9'h000, 0, 0);
    chk("st_iv_busy", busy, 1);
    chk("st_iv_vec_count", vec_count, 0);
    chk("st_iv_err_count", err_count, 0);
    vec(1, 0, 9'h000, 9'h1FF, 0, 0);
    vec(1, 0, 9'h1FF, 9'h000, 0, 0);
    vec(1, 0, 9'h080, 9'h080, 0, 0);
    vec(1, 0, 9'h081, 9'h080, 0, 0);
    final_chk("fresh", 4, 3, 0, 511, 1023, 0, 1);

    @(negedge clk);
    #1;
    chk("final_queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
